// File: rtl/traffic_pkg.sv
// Shared state encoding, lamp patterns and lamp decode for the timed traffic controller.
package traffic_pkg;

    localparam logic [2:0] ST_MAIN_GREEN = 3'd0;
    localparam logic [2:0] ST_MAIN_YEL   = 3'd1;
    localparam logic [2:0] ST_ALLRED_A   = 3'd2;
    localparam logic [2:0] ST_SEC_GREEN  = 3'd3;
    localparam logic [2:0] ST_SEC_YEL    = 3'd4;
    localparam logic [2:0] ST_ALLRED_B   = 3'd5;
    localparam logic [2:0] ST_FLASH      = 3'd6;

    localparam logic [2:0] LAMP_R   = 3'b100;
    localparam logic [2:0] LAMP_Y   = 3'b010;
    localparam logic [2:0] LAMP_G   = 3'b001;
    localparam logic [2:0] LAMP_OFF = 3'b000;

    // Returns {lo_lamp, ns_lamp} for a state; flash mode shows main yellow / side red while blink is high.
    function automatic logic [5:0] lamp_decode(input logic [2:0] st, input logic blink);
        logic [5:0] lamps;
        case (st)
            ST_MAIN_GREEN: lamps = {LAMP_G, LAMP_R};
            ST_MAIN_YEL:   lamps = {LAMP_Y, LAMP_R};
            ST_ALLRED_A:   lamps = {LAMP_R, LAMP_R};
            ST_SEC_GREEN:  lamps = {LAMP_R, LAMP_G};
            ST_SEC_YEL:    lamps = {LAMP_R, LAMP_Y};
            ST_ALLRED_B:   lamps = {LAMP_R, LAMP_R};
            ST_FLASH:      lamps = blink ? {LAMP_Y, LAMP_R} : {LAMP_OFF, LAMP_OFF};
            default:       lamps = {LAMP_R, LAMP_R};
        endcase
        return lamps;
    endfunction

endpackage

// File: rtl/traffic_phase_timer.sv
// Saturating phase timer: counts ticks, synchronously cleared on every phase change.
module traffic_phase_timer #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             tick,
    input  logic             clr,
    output logic [CNT_W-1:0] timer
);

    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

    logic [CNT_W-1:0] timer_r;

    // Counter register: clear has priority over the tick increment, which stops at all-ones.
    always_ff @(posedge clk) begin
        if (rst) begin
            timer_r <= CNT_ZERO;
        end else if (clr) begin
            timer_r <= CNT_ZERO;
        end else if (tick && (timer_r != CNT_MAX)) begin
            timer_r <= timer_r + CNT_ONE;
        end else begin
            timer_r <= timer_r;
        end
    end

    assign timer = timer_r;

endmodule

// File: rtl/traffic_controller_timed.sv
// Timed two-road traffic controller: Moore FSM with yellow/all-red clearance,
// min/max green timing, latched side-road demand and a flashing maintenance mode.
module traffic_controller_timed
    import traffic_pkg::*;
#(
    parameter int N_MAIN   = 2,
    parameter int N_SEC    = 2,
    parameter int CNT_W    = 8,
    parameter int MAIN_MIN = 8,
    parameter int SEC_MIN  = 4,
    parameter int SEC_MAX  = 12,
    parameter int YEL_T    = 3,
    parameter int ALLRED_T = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              tick,
    input  logic              flash,
    input  logic [N_MAIN-1:0] sens_main,
    input  logic [N_SEC-1:0]  sens_sec,
    output logic [2:0]        lo_lamp,
    output logic [2:0]        ns_lamp,
    output logic              L_O,
    output logic              N_S,
    output logic [2:0]        state_o,
    output logic              sec_req_o
);

    // Compare against value-1 because the timer reads 0 during the first tick of a phase.
    localparam logic [CNT_W-1:0] MAIN_MIN_M1 = CNT_W'(MAIN_MIN - 1);
    localparam logic [CNT_W-1:0] SEC_MIN_M1  = CNT_W'(SEC_MIN - 1);
    localparam logic [CNT_W-1:0] SEC_MAX_M1  = CNT_W'(SEC_MAX - 1);
    localparam logic [CNT_W-1:0] YEL_M1      = CNT_W'(YEL_T - 1);
    localparam logic [CNT_W-1:0] ALLRED_M1   = CNT_W'(ALLRED_T - 1);

    logic [2:0]       state_r;
    logic [2:0]       next_state_s;
    logic             sec_req_r;
    logic             next_sec_req_s;
    logic             blink_r;
    logic             next_blink_s;
    logic [2:0]       lo_lamp_r;
    logic [2:0]       ns_lamp_r;
    logic [5:0]       next_lamps_s;
    logic [CNT_W-1:0] timer_s;
    logic             timer_clr_s;
    logic             sec_now_s;
    logic             main_now_s;
    logic             sec_dem_s;

    assign sec_now_s   = |sens_sec;
    assign main_now_s  = |sens_main;
    assign sec_dem_s   = sec_req_r | sec_now_s;
    assign timer_clr_s = (next_state_s != state_r);

    traffic_phase_timer #(
        .CNT_W (CNT_W)
    ) u_timer (
        .clk   (clk),
        .rst   (rst),
        .tick  (tick),
        .clr   (timer_clr_s),
        .timer (timer_s)
    );

    // Next-state logic: flash overrides everything, timed phases only advance on tick.
    always_comb begin
        next_state_s = state_r;
        if (flash) begin
            next_state_s = ST_FLASH;
        end else if (state_r == ST_FLASH) begin
            next_state_s = ST_ALLRED_B;
        end else if (tick) begin
            case (state_r)
                ST_MAIN_GREEN: begin
                    if (sec_dem_s && (timer_s >= MAIN_MIN_M1)) next_state_s = ST_MAIN_YEL;
                    else next_state_s = ST_MAIN_GREEN;
                end
                ST_MAIN_YEL: begin
                    if (timer_s == YEL_M1) next_state_s = ST_ALLRED_A;
                    else next_state_s = ST_MAIN_YEL;
                end
                ST_ALLRED_A: begin
                    if (timer_s == ALLRED_M1) next_state_s = ST_SEC_GREEN;
                    else next_state_s = ST_ALLRED_A;
                end
                ST_SEC_GREEN: begin
                    if ((timer_s == SEC_MAX_M1) ||
                        ((timer_s >= SEC_MIN_M1) && (!sec_now_s || main_now_s)))
                        next_state_s = ST_SEC_YEL;
                    else next_state_s = ST_SEC_GREEN;
                end
                ST_SEC_YEL: begin
                    if (timer_s == YEL_M1) next_state_s = ST_ALLRED_B;
                    else next_state_s = ST_SEC_YEL;
                end
                ST_ALLRED_B: begin
                    if (timer_s == ALLRED_M1) next_state_s = ST_MAIN_GREEN;
                    else next_state_s = ST_ALLRED_B;
                end
                default: next_state_s = ST_MAIN_GREEN;
            endcase
        end else begin
            next_state_s = state_r;
        end
    end

    // Demand latch and flash blink phase; clearing on entry to side green beats a simultaneous set.
    always_comb begin
        next_sec_req_s = sec_req_r;
        next_blink_s   = 1'b0;
        if ((next_state_s == ST_SEC_GREEN) && (state_r != ST_SEC_GREEN)) begin
            next_sec_req_s = 1'b0;
        end else if (sec_now_s && (state_r != ST_SEC_GREEN)) begin
            next_sec_req_s = 1'b1;
        end else begin
            next_sec_req_s = sec_req_r;
        end
        if (next_state_s != ST_FLASH) begin
            next_blink_s = 1'b0;
        end else if (state_r != ST_FLASH) begin
            next_blink_s = 1'b1;
        end else if (tick) begin
            next_blink_s = ~blink_r;
        end else begin
            next_blink_s = blink_r;
        end
        next_lamps_s = lamp_decode(next_state_s, next_blink_s);
    end

    // State, demand, blink and lamp registers; lamps are decoded from the next state so they switch with it.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r   <= ST_MAIN_GREEN;
            sec_req_r <= 1'b0;
            blink_r   <= 1'b0;
            lo_lamp_r <= LAMP_G;
            ns_lamp_r <= LAMP_R;
        end else begin
            state_r   <= next_state_s;
            sec_req_r <= next_sec_req_s;
            blink_r   <= next_blink_s;
            lo_lamp_r <= next_lamps_s[5:3];
            ns_lamp_r <= next_lamps_s[2:0];
        end
    end

    assign lo_lamp   = lo_lamp_r;
    assign ns_lamp   = ns_lamp_r;
    assign L_O       = lo_lamp_r[0];
    assign N_S       = ns_lamp_r[0];
    assign state_o   = state_r;
    assign sec_req_o = sec_req_r;

endmodule

// File: tb/tb_traffic_controller_timed.sv
// Self-checking bench for traffic_controller_timed: directed scenarios plus
// randomized stimulus, compared every cycle against a phase/dwell reference model.
module tb_traffic_controller_timed;
    import traffic_pkg::*;

    localparam int MAIN_MIN = 8;
    localparam int SEC_MIN  = 4;
    localparam int SEC_MAX  = 12;
    localparam int YEL_T    = 3;
    localparam int ALLRED_T = 1;

    localparam int PH_MG  = 0;
    localparam int PH_MY  = 1;
    localparam int PH_ARA = 2;
    localparam int PH_SG  = 3;
    localparam int PH_SY  = 4;
    localparam int PH_ARB = 5;
    localparam int PH_FL  = 6;

    logic       clk = 1'b0;
    logic       rst, tick, flash;
    logic [1:0] sens_main, sens_sec;
    logic [2:0] lo_lamp, ns_lamp, state_o;
    logic       L_O, N_S, sec_req_o;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: phase ring with per-phase dwell in ticks
    int dur [6] = '{MAIN_MIN, YEL_T, ALLRED_T, SEC_MAX, YEL_T, ALLRED_T};
    logic [2:0] st_tab [7] = '{ST_MAIN_GREEN, ST_MAIN_YEL, ST_ALLRED_A, ST_SEC_GREEN,
                               ST_SEC_YEL, ST_ALLRED_B, ST_FLASH};
    int m_ph = PH_MG;
    int m_el = 0;
    bit m_req = 1'b0;
    bit m_blink = 1'b0;

    logic [2:0] obs_lo [26];
    logic [2:0] obs_ns [26];
    logic       obs_req [26];

    always #5 clk = ~clk;

    traffic_controller_timed dut (
        .clk       (clk),
        .rst       (rst),
        .tick      (tick),
        .flash     (flash),
        .sens_main (sens_main),
        .sens_sec  (sens_sec),
        .lo_lamp   (lo_lamp),
        .ns_lamp   (ns_lamp),
        .L_O       (L_O),
        .N_S       (N_S),
        .state_o   (state_o),
        .sec_req_o (sec_req_o)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [2:0] exp_lo(input int ph, input bit blink);
        case (ph)
            PH_MG:   return 3'b001;
            PH_MY:   return 3'b010;
            PH_FL:   return blink ? 3'b010 : 3'b000;
            default: return 3'b100;
        endcase
    endfunction

    function automatic logic [2:0] exp_ns(input int ph, input bit blink);
        case (ph)
            PH_SG:   return 3'b001;
            PH_SY:   return 3'b010;
            PH_FL:   return blink ? 3'b100 : 3'b000;
            default: return 3'b100;
        endcase
    endfunction

    task automatic model_step();
        int nph;
        bit sec_now;
        bit main_now;
        bit dem;
        sec_now  = |sens_sec;
        main_now = |sens_main;
        dem      = m_req || sec_now;
        if (rst) begin
            m_ph = PH_MG; m_el = 0; m_req = 1'b0; m_blink = 1'b0;
            return;
        end
        nph = m_ph;
        if (flash) nph = PH_FL;
        else if (m_ph == PH_FL) nph = PH_ARB;
        else if (tick) begin
            case (m_ph)
                PH_MG: if (dem && (m_el + 1 >= MAIN_MIN)) nph = PH_MY;
                PH_SG: if ((m_el + 1 >= SEC_MAX) ||
                           ((m_el + 1 >= SEC_MIN) && (!sec_now || main_now))) nph = PH_SY;
                default: if (m_el + 1 == dur[m_ph]) nph = (m_ph + 1) % 6;
            endcase
        end
        if (nph == PH_SG && m_ph != PH_SG) m_req = 1'b0;
        else if (sec_now && m_ph != PH_SG) m_req = 1'b1;
        if (nph == PH_FL && m_ph != PH_FL) m_blink = 1'b1;
        else if (nph == PH_FL && tick) m_blink = !m_blink;
        if (nph != m_ph) m_el = 0;
        else if (tick && m_el < 255) m_el++;
        m_ph = nph;
    endtask

    task automatic check_outputs();
        chk("lo_lamp", 32'(lo_lamp), 32'(exp_lo(m_ph, m_blink)));
        chk("ns_lamp", 32'(ns_lamp), 32'(exp_ns(m_ph, m_blink)));
        chk("L_O", 32'(L_O), 32'(exp_lo(m_ph, m_blink) == 3'b001));
        chk("N_S", 32'(N_S), 32'(exp_ns(m_ph, m_blink) == 3'b001));
        chk("sec_req_o", 32'(sec_req_o), 32'(m_req));
        chk("state_o", 32'(state_o), 32'(st_tab[m_ph]));
    endtask

    task automatic cyc();
        @(posedge clk);
        model_step();
        #1;
        check_outputs();
    endtask

    task automatic do_reset(input int n);
        rst = 1'b1;
        repeat (n) cyc();
        rst = 1'b0;
    endtask

    task automatic run_until_ns(input logic [2:0] want, input string tag);
        int k = 0;
        while (ns_lamp !== want && k < 200) begin
            cyc();
            k++;
        end
        chk(tag, 32'(ns_lamp), 32'(want));
    endtask

    // Counts the next side-green run; optionally raises main demand at green cycle main_at.
    task automatic measure_green(input int main_at, output int len);
        int k = 0;
        len = 0;
        while (k < 300) begin
            if (main_at > 0 && len == main_at) sens_main = 2'b01;
            cyc();
            k++;
            if (ns_lamp === 3'b001) len++;
            else if (len > 0) break;
        end
        sens_main = 2'b00;
    endtask

    initial begin
        int len;
        int mg_len;
        bit mg_run;
        rst = 1'b1; tick = 1'b1; flash = 1'b0; sens_main = 2'b00; sens_sec = 2'b00;

        // 1: idle main green
        do_reset(2);
        chk("reset_lo", 32'(lo_lamp), 32'(3'b001));
        chk("reset_ns", 32'(ns_lamp), 32'(3'b100));
        repeat (50) cyc();
        chk("idle_lo", 32'(lo_lamp), 32'(3'b001));
        chk("idle_req", 32'(sec_req_o), 32'(1'b0));

        // 2: single side pulse at cycle 2
        do_reset(1);
        obs_lo[0] = lo_lamp; obs_ns[0] = ns_lamp; obs_req[0] = sec_req_o;
        for (int c = 0; c < 25; c++) begin
            sens_sec = (c == 2) ? 2'b01 : 2'b00;
            cyc();
            obs_lo[c+1] = lo_lamp; obs_ns[c+1] = ns_lamp; obs_req[c+1] = sec_req_o;
        end
        chk("p_mg7", 32'(obs_lo[7]), 32'(3'b001));
        chk("p_my8", 32'(obs_lo[8]), 32'(3'b010));
        chk("p_my10", 32'(obs_lo[10]), 32'(3'b010));
        chk("p_ara11", 32'({obs_lo[11], obs_ns[11]}), 32'(6'b100100));
        chk("p_sg12", 32'(obs_ns[12]), 32'(3'b001));
        chk("p_sg15", 32'(obs_ns[15]), 32'(3'b001));
        chk("p_sy16", 32'(obs_ns[16]), 32'(3'b010));
        chk("p_arb19", 32'({obs_lo[19], obs_ns[19]}), 32'(6'b100100));
        chk("p_mg20", 32'(obs_lo[20]), 32'(3'b001));
        chk("p_req2", 32'(obs_req[2]), 32'(1'b0));
        chk("p_req3", 32'(obs_req[3]), 32'(1'b1));
        chk("p_req11", 32'(obs_req[11]), 32'(1'b1));
        chk("p_req12", 32'(obs_req[12]), 32'(1'b0));

        // 3: held side demand -> max green, then main demand shortens it
        do_reset(1);
        sens_sec = 2'b11;
        measure_green(0, len);
        chk("sec_max_len", 32'(len), 32'(SEC_MAX));
        measure_green(2, len);
        chk("sec_main_len", 32'(len), 32'(SEC_MIN));
        sens_sec = 2'b00;

        // 4: tick every 4th cycle
        do_reset(1);
        sens_sec = 2'b01;
        mg_len = 1; mg_run = 1'b1;
        for (int k = 0; k < 80; k++) begin
            tick = (k % 4 == 3);
            cyc();
            if (mg_run && lo_lamp === 3'b001) mg_len++;
            else mg_run = 1'b0;
        end
        chk("slow_mg_len", 32'(mg_len), 32'(4 * MAIN_MIN));
        tick = 1'b1; sens_sec = 2'b00;

        // 5: flash during side green
        do_reset(1);
        sens_sec = 2'b01; cyc(); sens_sec = 2'b00;
        run_until_ns(3'b001, "fl_reach_sg");
        flash = 1'b1; cyc();
        chk("fl_entry", 32'({lo_lamp, ns_lamp}), 32'(6'b010100));
        cyc();
        chk("fl_off", 32'({lo_lamp, ns_lamp}), 32'(6'b000000));
        sens_sec = 2'b10; cyc(); sens_sec = 2'b00;
        repeat (4) cyc();
        flash = 1'b0; cyc();
        chk("fl_exit_arb", 32'({lo_lamp, ns_lamp}), 32'(6'b100100));
        cyc();
        chk("fl_exit_mg", 32'(lo_lamp), 32'(3'b001));
        chk("fl_req_held", 32'(sec_req_o), 32'(1'b1));

        // 6: reset in side yellow
        run_until_ns(3'b010, "rst_reach_sy");
        rst = 1'b1; cyc(); rst = 1'b0;
        chk("rst_lamps", 32'({lo_lamp, ns_lamp}), 32'(6'b001100));
        chk("rst_state", 32'(state_o), 32'(ST_MAIN_GREEN));
        chk("rst_req", 32'(sec_req_o), 32'(1'b0));
        repeat (12) cyc();

        // Random stimulus
        for (int k = 0; k < 3000; k++) begin
            tick = ($urandom_range(0, 2) != 0);
            if ($urandom_range(0, 59) == 0) flash = ~flash;
            sens_sec  = ($urandom_range(0, 9) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
            sens_main = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
            rst = ($urandom_range(0, 499) == 0);
            cyc();
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/traffic_controller_timed.md
Name: traffic_controller_timed

Overview:
Timed, sensor-actuated successor to the combinational two-road traffic controller. It uses a Moore FSM with yellow and all-red clearance phases, min/max green timing, a latched secondary-road demand, and a flashing maintenance mode. Sensor count and phase timings are parametrised. It sits between the intersection sensor inputs and the lamp drivers, and keeps the legacy L_O/N_S green outputs for compatibility.

Parameters:
N_MAIN, 2, number of main-road (L_O) sensors
N_SEC, 2, number of secondary-road (N_S) sensors
CNT_W, 8, phase timer width; every timing below must satisfy 1 <= value <= 2^CNT_W-1
MAIN_MIN, 8, minimum main green, in ticks
SEC_MIN, 4, minimum secondary green, in ticks
SEC_MAX, 12, maximum secondary green, in ticks; SEC_MIN <= SEC_MAX
YEL_T, 3, yellow duration, in ticks
ALLRED_T, 1, all-red clearance duration, in ticks

Ports:
clk  in  1  system clock, rising edge
rst  in  1  synchronous, active-high reset
tick  in  1  one-cycle timebase enable; all timing counts ticks
flash  in  1  maintenance flash request, level-sensitive
sens_main  in  N_MAIN  main-road vehicle sensors, active high
sens_sec  in  N_SEC  secondary-road vehicle sensors, active high
lo_lamp  out  3  main-road lamps, bit order {R,Y,G}
ns_lamp  out  3  secondary-road lamps, bit order {R,Y,G}
L_O  out  1  main green, equal to lo_lamp[0]
N_S  out  1  secondary green, equal to ns_lamp[0]
state_o  out  3  current FSM state encoding, for debug
sec_req_o  out  1  latched secondary demand

Behaviour:
- Clock and reset: one clock, clk. rst is synchronous and active-high. rst has priority over every other input.
- Reset values: state=MAIN_GREEN, timer=0, sec_req=0, blink=0, lo_lamp=001, ns_lamp=100, L_O=1, N_S=0.
- States: MAIN_GREEN, MAIN_YEL, ALLRED_A, SEC_GREEN, SEC_YEL, ALLRED_B, FLASH.
- Outputs are Moore, decoded from state only, with no input-to-output path. They change on the same edge as the state.
- Lamp decode per state (lo/ns):
  - MAIN_GREEN: 001/100
  - MAIN_YEL: 010/100
  - ALLRED_A, ALLRED_B: 100/100
  - SEC_GREEN: 100/001
  - SEC_YEL: 100/010
  - FLASH: blink ? 010/100 : 000/000
- Timer:
  - Increments on tick and saturates at 2^CNT_W-1.
  - Clears to 0 on every state change, including entry to and exit from FLASH.
- Demand: sec_dem = sec_req | (|sens_sec).
- sec_req:
  - Set on any edge where |sens_sec=1 and state != SEC_GREEN.
  - Cleared on the edge entering SEC_GREEN; clear wins over a simultaneous set.
- Transitions (non-FLASH states evaluate only on edges with tick=1):
  - MAIN_GREEN -> MAIN_YEL when sec_dem && timer >= MAIN_MIN-1. With no demand, main green holds indefinitely.
  - MAIN_YEL -> ALLRED_A when timer == YEL_T-1.
  - ALLRED_A -> SEC_GREEN when timer == ALLRED_T-1.
  - SEC_GREEN -> SEC_YEL when timer == SEC_MAX-1, OR when timer >= SEC_MIN-1 && (!(|sens_sec) || |sens_main) (gap-out or main-road demand).
  - SEC_YEL -> ALLRED_B when timer == YEL_T-1.
  - ALLRED_B -> MAIN_GREEN when timer == ALLRED_T-1.
- Resulting dwell: each timed phase lasts exactly its parameter in ticks.
- FLASH:
  - flash=1 moves any state to FLASH on the next edge, regardless of tick. flash has priority over timed transitions.
  - blink is set to 1 on entry and toggles on each tick while in FLASH.
  - flash=0 in FLASH moves to ALLRED_B (timer=0) on the next edge, then the normal sequence resumes.
  - sec_req keeps setting and is held across FLASH.
- Simultaneous demand: sens_main and sens_sec both active in MAIN_GREEN gives the normal sequence; main demand only shortens SEC_GREEN.
- Reset mid-phase: the next edge gives MAIN_GREEN and reset values, discarding any in-progress yellow or all-red phase.

Decomposition:
- Package traffic_pkg: state enum/localparams (3-bit), lamp constants LAMP_R=100, LAMP_Y=010, LAMP_G=001, LAMP_OFF=000.
- One sub-module, traffic_phase_timer:
  - Holds the CNT_W saturating counter with tick enable and synchronous clear.
  - Output is timer.
- The FSM, demand latch and lamp decode stay in the top module.

Test Plan:
1. rst for 2 cycles, tick=1, all sensors 0, run 50 cycles -> lo_lamp=001 and ns_lamp=100 throughout; L_O=1, N_S=0; sec_req_o=0.
2. tick=1, pulse sens_sec=01 for one cycle at cycle 2 after reset (cycle 0 = first cycle after reset) -> sequence:
   - MAIN_GREEN cycles 0-7, MAIN_YEL 8-10, ALLRED_A 11, SEC_GREEN 12-15 (gap-out), SEC_YEL 16-18, ALLRED_B 19, MAIN_GREEN from 20.
   - sec_req_o high cycles 3-11.
3. tick=1, sens_sec=11 held high, sens_main=0 -> SEC_GREEN lasts 12 cycles (max); sec_req re-latches during SEC_YEL; the next cycle starts after 8 main-green cycles. Then assert sens_main=01 at SEC_GREEN cycle 2 -> SEC_GREEN ends after 4 cycles.
4. tick asserted every 4th cycle, sens_sec held from reset -> MAIN_GREEN lasts 32 clk cycles, MAIN_YEL 12, ALLRED_A 4; state changes occur only on tick edges.
5. flash=1 during SEC_GREEN:
   - Next edge: FLASH, lo/ns=010/100, then 000/000 after the next tick, alternating per tick.
   - flash=0: next edge ALLRED_B (100/100) for 1 tick, then MAIN_GREEN.
   - A sens_sec pulse during FLASH leaves sec_req_o=1 after exit.
6. rst=1 for one cycle during SEC_YEL -> next edge lo_lamp=001, ns_lamp=100, state_o=MAIN_GREEN, sec_req_o=0, timer restarts from 0.
